draw_sequencer: RTL

//  Parametrised per-frame draw scheduler for the game display path. Generalises
//  the fixed wall/bird alternation to N sprite channels. Each frame runs three

---
 rtl/draw_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/draw_sequencer.sv
// draw_sequencer: per-frame erase/update/redraw scheduler over N sprite channels
module draw_sequencer #(
    parameter int N_SPR   = 2,
    parameter int SEL_W   = 1,
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             collision,
    input  logic             frame_start,
    input  logic [N_SPR-1:0] sprite_en,
    input  logic [N_SPR-1:0] draw_done,
    output logic [N_SPR-1:0] draw_req,
    output logic             draw_erase,
    output logic [SEL_W-1:0] sel,
    output logic             update,
    output logic             busy,
    output logic             game_over,
    output logic [7:0]       overrun_cnt,
    output logic [N_SPR-1:0] timeout_err
);
    localparam int NW = $clog2(N_SPR + 1);
    typedef enum logic [2:0] {IDLE, WAIT, ESEL, ERASE, UPD, DSEL, DRAW} state_t;
    state_t           state;
    logic [N_SPR-1:0] en_lat;
    logic             pending;
    logic [NW-1:0]    nxt;
    logic [TO_W-1:0]  to_cnt;
    logic             found;
    logic [SEL_W-1:0] idx;
    logic             busy_st;
    logic             to_hit;
    assign busy_st = !(state == IDLE || state == WAIT);
    assign to_hit  = to_cnt == TO_W'(TIMEOUT - 1);
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N_SPR - 1; i >= 0; i--)
            if (en_lat[i] && NW'(i) >= nxt) begin
                found = 1'b1;
                idx   = SEL_W'(i);
            end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            en_lat      <= '0;
            pending     <= 1'b0;
            nxt         <= '0;
            to_cnt      <= '0;
            draw_req    <= '0;
            draw_erase  <= 1'b0;
            sel         <= '0;
            update      <= 1'b0;
            busy        <= 1'b0;
            game_over   <= 1'b0;
            overrun_cnt <= '0;
            timeout_err <= '0;
        end else begin
            update    <= 1'b0;
            game_over <= game_over | collision;
            if (frame_start && busy_st) begin
                if (pending) overrun_cnt <= overrun_cnt + {7'd0, overrun_cnt != 8'hff};
                else pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    pending <= 1'b0;
                    if (go && frame_start) begin
                        en_lat <= sprite_en;
                        nxt    <= '0;
                        busy   <= 1'b1;
                        state  <= DSEL;
                    end
                end
                WAIT: begin
                    if (!go) begin
                        pending <= 1'b0;
                        state   <= IDLE;
                    end else if (frame_start || pending) begin
                        en_lat  <= sprite_en;
                        pending <= 1'b0;
                        nxt     <= '0;
                        busy    <= 1'b1;
                        state   <= ESEL;
                    end
                end
                ESEL, DSEL: begin
                    if (found) begin
                        sel        <= idx;
                        nxt        <= NW'(idx) + NW'(1);
                        draw_req   <= N_SPR'(1) << idx;
                        draw_erase <= state == ESEL;
                        to_cnt     <= '0;
                        state      <= state == ESEL ? ERASE : DRAW;
                    end else if (state == ESEL) begin
                        nxt    <= '0;
                        update <= !(game_over | collision);
                        state  <= UPD;
                    end else begin
                        nxt   <= '0;
                        busy  <= 1'b0;
                        state <= WAIT;
                    end
                end
                ERASE, DRAW: begin
                    if (draw_done[sel] || to_hit) begin
                        draw_req   <= '0;
                        draw_erase <= 1'b0;
                        if (!draw_done[sel]) timeout_err[sel] <= 1'b1;
                        state <= state == ERASE ? ESEL : DSEL;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                UPD:     state <= DSEL;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
